// File: rtl/boot_pkg.sv
// Shared types and constants for the UART boot loader.
package boot_pkg;

    typedef enum logic [2:0] {
        S_SYNC,
        S_ADDR,
        S_LEN,
        S_DATA,
        S_CHK,
        S_DONE
    } boot_state_e;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_BITS,
        RX_STOP
    } rx_state_e;

    localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;
    localparam int         ADDR_BYTES    = 4;
    localparam int         LEN_BYTES     = 4;

endpackage

// File: rtl/boot_if.sv
// Boot write port plus loader status, seen from the loader (master) and the memory/SoC side (slave).
interface boot_if;
    // Handshake: boot_wr_en is a one-cycle strobe with no ready; the slave must take
    // boot_wr_addr/boot_wr_data on every cycle boot_wr_en is high. Address/data hold otherwise.
    logic        boot_wr_en;
    logic [31:0] boot_wr_addr;
    logic [7:0]  boot_wr_data;
    logic        core_hold;
    logic        boot_done;
    logic        boot_err;

    modport master (
        output boot_wr_en, boot_wr_addr, boot_wr_data, core_hold, boot_done, boot_err
    );

    modport slave (
        input boot_wr_en, boot_wr_addr, boot_wr_data, core_hold, boot_done, boot_err
    );
endinterface

// File: rtl/boot_uart_rx.sv
// 8N1 UART receiver: 2-flop synchronizer, mid-bit sampling, glitch-rejecting start detection.
module boot_uart_rx
    import boot_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic      clk,
    input  logic      reset,
    input  logic      uart_rx,
    output logic      rx_valid,
    output logic [7:0] rx_byte,
    output logic      rx_ferr,
    output rx_state_e rx_state
);

    localparam logic [15:0] HALF_M1 = 16'(CLKS_PER_BIT / 2 - 1);
    localparam logic [15:0] FULL_M1 = 16'(CLKS_PER_BIT - 1);

    // [0],[1] form the synchronizer; [2] is the previous synchronized value for edge detect.
    logic [2:0]  sync_q;
    logic        rx_s;
    logic [15:0] cnt;
    logic [2:0]  bit_idx;
    logic [7:0]  shreg;

    assign rx_s = sync_q[1];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q   <= 3'b111;
            rx_state <= RX_IDLE;
            cnt      <= '0;
            bit_idx  <= '0;
            shreg    <= '0;
            rx_valid <= 1'b0;
            rx_byte  <= '0;
            rx_ferr  <= 1'b0;
        end else begin
            sync_q   <= {sync_q[1:0], uart_rx};
            rx_valid <= 1'b0;
            case (rx_state)
                RX_IDLE: begin
                    if (sync_q[2] && !rx_s) begin
                        rx_state <= RX_START;
                        cnt      <= '0;
                    end
                end
                RX_START: begin
                    if (cnt == HALF_M1) begin
                        cnt      <= '0;
                        bit_idx  <= '0;
                        rx_state <= rx_s ? RX_IDLE : RX_BITS;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                RX_BITS: begin
                    if (cnt == FULL_M1) begin
                        cnt     <= '0;
                        shreg   <= {rx_s, shreg[7:1]};
                        bit_idx <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) rx_state <= RX_STOP;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                RX_STOP: begin
                    if (cnt == FULL_M1) begin
                        cnt      <= '0;
                        rx_valid <= 1'b1;
                        rx_byte  <= shreg;
                        rx_ferr  <= !rx_s;
                        rx_state <= RX_IDLE;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                default: rx_state <= RX_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/boot_loader.sv
// Frame parser: SYNC, ADDR, LEN, payload, XOR checksum; writes payload to the boot port
// and releases core_hold once the checksum matches.
module boot_loader
    import boot_pkg::*;
#(
    parameter int         CLKS_PER_BIT = 434,
    parameter logic [7:0] SYNC_BYTE    = SYNC_BYTE_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        uart_rx,
    boot_if.master      bus,
    output boot_state_e dbg_state,
    output rx_state_e   dbg_rx_state
);

    boot_state_e state;
    logic        rx_valid;
    logic [7:0]  rx_byte;
    logic        rx_ferr;
    logic [31:0] addr;
    logic [31:0] len;
    logic [31:0] len_next;
    logic [31:0] idx;
    logic [7:0]  xor_acc;
    logic [1:0]  byte_cnt;
    logic        abort;

    boot_uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
        .clk      (clk),
        .reset    (reset),
        .uart_rx  (uart_rx),
        .rx_valid (rx_valid),
        .rx_byte  (rx_byte),
        .rx_ferr  (rx_ferr),
        .rx_state (dbg_rx_state)
    );

    assign dbg_state = state;
    assign len_next  = {rx_byte, len[31:8]};
    // A bad stop bit only matters mid-frame; while hunting for SYNC or after DONE it is dropped.
    assign abort     = rx_valid && rx_ferr && (state != S_SYNC) && (state != S_DONE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state            <= S_SYNC;
            addr             <= '0;
            len              <= '0;
            idx              <= '0;
            xor_acc          <= '0;
            byte_cnt         <= '0;
            bus.boot_wr_en   <= 1'b0;
            bus.boot_wr_addr <= '0;
            bus.boot_wr_data <= '0;
            bus.core_hold    <= 1'b1;
            bus.boot_done    <= 1'b0;
            bus.boot_err     <= 1'b0;
        end else begin
            bus.boot_wr_en <= 1'b0;
            if (abort) begin
                bus.boot_err <= 1'b1;
                state        <= S_SYNC;
            end else if (rx_valid && !rx_ferr) begin
                case (state)
                    S_SYNC: begin
                        if (rx_byte == SYNC_BYTE) begin
                            bus.boot_err <= 1'b0;
                            byte_cnt     <= '0;
                            idx          <= '0;
                            xor_acc      <= '0;
                            state        <= S_ADDR;
                        end
                    end
                    S_ADDR: begin
                        addr     <= {rx_byte, addr[31:8]};
                        byte_cnt <= byte_cnt + 2'd1;
                        if (byte_cnt == 2'(ADDR_BYTES - 1)) begin
                            byte_cnt <= '0;
                            state    <= S_LEN;
                        end
                    end
                    S_LEN: begin
                        len      <= len_next;
                        byte_cnt <= byte_cnt + 2'd1;
                        if (byte_cnt == 2'(LEN_BYTES - 1)) begin
                            byte_cnt <= '0;
                            state    <= (len_next == 32'd0) ? S_CHK : S_DATA;
                        end
                    end
                    S_DATA: begin
                        bus.boot_wr_en   <= 1'b1;
                        bus.boot_wr_addr <= addr + idx;
                        bus.boot_wr_data <= rx_byte;
                        xor_acc          <= xor_acc ^ rx_byte;
                        idx              <= idx + 32'd1;
                        if (idx == len - 32'd1) state <= S_CHK;
                    end
                    S_CHK: begin
                        if (rx_byte == xor_acc) begin
                            bus.boot_done <= 1'b1;
                            bus.core_hold <= 1'b0;
                            state         <= S_DONE;
                        end else begin
                            bus.boot_err <= 1'b1;
                            state        <= S_SYNC;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_boot_loader.sv
// Randomized bench for boot_loader: serial frame driver, write scoreboard, per-scenario status checks.
module tb_boot_loader;
  import boot_pkg::*;

  localparam int CPB = 16;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic uart_rx = 1'b1;
  boot_state_e dbg_state;
  rx_state_e dbg_rx_state;

  boot_if bif();

  boot_loader #(.CLKS_PER_BIT(CPB), .SYNC_BYTE(8'hA5)) dut (
    .clk          (clk),
    .reset        (reset),
    .uart_rx      (uart_rx),
    .bus          (bif),
    .dbg_state    (dbg_state),
    .dbg_rx_state (dbg_rx_state)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [39:0] exp_q[$];
  logic [7:0] pl_q[$];
  logic [39:0] mon_e;
  logic prev_en = 1'b0;

  // Scoreboard: every write strobe must match the next expected {addr, data}.
  always @(negedge clk) begin
    if (bif.boot_wr_en === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write got addr=%h data=%h required no write", bif.boot_wr_addr, bif.boot_wr_data);
      end else begin
        mon_e = exp_q.pop_front();
        if ({bif.boot_wr_addr, bif.boot_wr_data} !== mon_e) begin
          errors++;
          $display("FAIL write got addr=%h data=%h required addr=%h data=%h",
                   bif.boot_wr_addr, bif.boot_wr_data, mon_e[39:8], mon_e[7:0]);
        end
      end
      if (prev_en === 1'b1) begin
        errors++;
        $display("FAIL wr_en_width got >=2 cycles required 1");
      end
    end
    prev_en = bif.boot_wr_en;
  end

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    uart_rx = 1'b0;
    wait_clks(CPB);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      wait_clks(CPB);
    end
    uart_rx = stop;
    wait_clks(CPB);
    uart_rx = 1'b1;
    wait_clks($urandom_range(3, 12));
  endtask

  // Sends SYNC, ADDR, LEN=pl_q.size(), payload, CHK. ferr_at: payload index sent with a bad
  // stop bit (frame ends there). cut_at: stop after that many payload bytes.
  task automatic send_frame(input logic [31:0] a, input logic [7:0] chk, input int ferr_at, input int cut_at);
    logic [31:0] len;
    len = pl_q.size();
    send_byte(8'hA5, 1'b1);
    for (int i = 0; i < 4; i++) send_byte(a[8*i +: 8], 1'b1);
    for (int i = 0; i < 4; i++) send_byte(len[8*i +: 8], 1'b1);
    for (int i = 0; i < pl_q.size(); i++) begin
      if (i == cut_at) return;
      if (i == ferr_at) begin
        send_byte(pl_q[i], 1'b0);
        return;
      end
      send_byte(pl_q[i], 1'b1);
    end
    send_byte(chk, 1'b1);
  endtask

  // Reference model: payload byte i lands at (a + i) mod 2^32; a framing error drops that byte and the rest.
  task automatic model_frame(input logic [31:0] a, input int ferr_at);
    int n;
    n = (ferr_at < 0) ? pl_q.size() : ferr_at;
    for (int i = 0; i < n; i++) exp_q.push_back({a + 32'(i), pl_q[i]});
  endtask

  function automatic logic [7:0] payload_xor();
    logic [7:0] r;
    r = 8'h00;
    foreach (pl_q[i]) r = r ^ pl_q[i];
    return r;
  endfunction

  task automatic rand_payload(input int n);
    pl_q.delete();
    for (int i = 0; i < n; i++) pl_q.push_back(8'($urandom_range(0, 255)));
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    uart_rx = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    exp_q.delete();
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset();
    #1 reset = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({bif.boot_wr_en, bif.boot_wr_addr, bif.boot_wr_data, bif.core_hold, bif.boot_done, bif.boot_err} !==
        {1'b0, 32'h0, 8'h0, 1'b1, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_outputs got en=%b addr=%h data=%h hold=%b done=%b err=%b required 0 0 0 1 0 0",
               bif.boot_wr_en, bif.boot_wr_addr, bif.boot_wr_data, bif.core_hold, bif.boot_done, bif.boot_err);
    end
    checks++;
    if (dbg_state !== S_SYNC) begin
      errors++;
      $display("FAIL reset_state got %0d required %0d", dbg_state, S_SYNC);
    end
    reset = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_good_frame();
    pl_q = '{8'h11, 8'h22, 8'h33};
    model_frame(32'h100, -1);
    send_frame(32'h100, 8'h00, -1, -1);
    repeat (4) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL good_writes got %0d missing required 0", exp_q.size());
    end
    checks++;
    if ({bif.boot_done, bif.boot_err, bif.core_hold, dbg_state} !== {1'b1, 1'b0, 1'b0, S_DONE}) begin
      errors++;
      $display("FAIL good_status got done=%b err=%b hold=%b st=%0d required 1 0 0 %0d",
               bif.boot_done, bif.boot_err, bif.core_hold, dbg_state, S_DONE);
    end
    checks++;
    if ({bif.boot_wr_addr, bif.boot_wr_data} !== {32'h102, 8'h33}) begin
      errors++;
      $display("FAIL good_hold got addr=%h data=%h required 102 33", bif.boot_wr_addr, bif.boot_wr_data);
    end
    // Anything after DONE is ignored: the scoreboard has no entries for this frame.
    pl_q = '{8'h77};
    send_frame(32'h500, 8'h77, -1, -1);
    repeat (4) @(negedge clk);
    checks++;
    if ({bif.boot_done, bif.boot_err, bif.core_hold} !== 3'b100) begin
      errors++;
      $display("FAIL done_sticky got done=%b err=%b hold=%b required 1 0 0", bif.boot_done, bif.boot_err, bif.core_hold);
    end
  endtask

  task automatic test_bad_checksum();
    logic [31:0] a;
    do_reset();
    pl_q = '{8'h11, 8'h22, 8'h33};
    model_frame(32'h100, -1);
    send_frame(32'h100, 8'h55, -1, -1);
    repeat (4) @(negedge clk);
    checks++;
    if ({exp_q.size() == 0, bif.boot_done, bif.boot_err, bif.core_hold, dbg_state} !== {1'b1, 1'b0, 1'b1, 1'b1, S_SYNC}) begin
      errors++;
      $display("FAIL bad_chk got pend=%0d done=%b err=%b hold=%b st=%0d required 0 0 1 1 %0d",
               exp_q.size(), bif.boot_done, bif.boot_err, bif.core_hold, dbg_state, S_SYNC);
    end
    a = $urandom;
    rand_payload(4);
    model_frame(a, -1);
    send_frame(a, payload_xor(), -1, -1);
    repeat (4) @(negedge clk);
    checks++;
    if ({exp_q.size() == 0, bif.boot_done, bif.boot_err, bif.core_hold} !== 4'b1100) begin
      errors++;
      $display("FAIL bad_chk_recover got pend=%0d done=%b err=%b hold=%b required 0 1 0 0",
               exp_q.size(), bif.boot_done, bif.boot_err, bif.core_hold);
    end
  endtask

  task automatic test_noise_glitch();
    logic [31:0] a;
    do_reset();
    send_byte(8'h00, 1'b1);
    send_byte(8'hFF, 1'b1);
    send_byte(8'h3C, 1'b1);
    uart_rx = 1'b0;
    wait_clks(CPB / 4);
    uart_rx = 1'b1;
    wait_clks(CPB);
    checks++;
    if ({dbg_rx_state, dbg_state, bif.core_hold, bif.boot_err} !== {RX_IDLE, S_SYNC, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL glitch got rx_st=%0d st=%0d hold=%b err=%b required %0d %0d 1 0",
               dbg_rx_state, dbg_state, bif.core_hold, bif.boot_err, RX_IDLE, S_SYNC);
    end
    wait_clks(2 * CPB);
    a = $urandom;
    rand_payload(3);
    model_frame(a, -1);
    send_frame(a, payload_xor(), -1, -1);
    repeat (4) @(negedge clk);
    checks++;
    if ({exp_q.size() == 0, bif.boot_done, bif.boot_err, bif.core_hold} !== 4'b1100) begin
      errors++;
      $display("FAIL noise_frame got pend=%0d done=%b err=%b hold=%b required 0 1 0 0",
               exp_q.size(), bif.boot_done, bif.boot_err, bif.core_hold);
    end
  endtask

  task automatic test_framing_error();
    logic [31:0] a;
    do_reset();
    a = $urandom;
    rand_payload(3);
    model_frame(a, 1);
    send_frame(a, payload_xor(), 1, -1);
    repeat (4) @(negedge clk);
    checks++;
    if ({exp_q.size() == 0, bif.boot_done, bif.boot_err, bif.core_hold, dbg_state} !== {1'b1, 1'b0, 1'b1, 1'b1, S_SYNC}) begin
      errors++;
      $display("FAIL ferr got pend=%0d done=%b err=%b hold=%b st=%0d required 0 0 1 1 %0d",
               exp_q.size(), bif.boot_done, bif.boot_err, bif.core_hold, dbg_state, S_SYNC);
    end
  endtask

  task automatic test_edge_lengths();
    do_reset();
    pl_q.delete();
    send_frame(32'h2000, 8'h00, -1, -1);
    repeat (4) @(negedge clk);
    checks++;
    if ({bif.boot_done, bif.boot_err, bif.core_hold} !== 3'b100) begin
      errors++;
      $display("FAIL len0 got done=%b err=%b hold=%b required 1 0 0", bif.boot_done, bif.boot_err, bif.core_hold);
    end
    do_reset();
    rand_payload(2);
    model_frame(32'hFFFF_FFFF, -1);
    send_frame(32'hFFFF_FFFF, payload_xor(), -1, -1);
    repeat (4) @(negedge clk);
    checks++;
    if ({exp_q.size() == 0, bif.boot_done, bif.boot_wr_addr} !== {1'b1, 1'b1, 32'h0}) begin
      errors++;
      $display("FAIL wrap got pend=%0d done=%b last_addr=%h required 0 1 00000000",
               exp_q.size(), bif.boot_done, bif.boot_wr_addr);
    end
  endtask

  task automatic test_reset_mid_data();
    logic [31:0] a;
    do_reset();
    a = $urandom;
    rand_payload(3);
    exp_q.push_back({a, pl_q[0]});
    send_frame(a, payload_xor(), -1, 1);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if ({exp_q.size() == 0, bif.boot_wr_en, bif.boot_wr_addr, bif.boot_wr_data, bif.core_hold, bif.boot_done,
         bif.boot_err, dbg_state} !== {1'b1, 1'b0, 32'h0, 8'h0, 1'b1, 1'b0, 1'b0, S_SYNC}) begin
      errors++;
      $display("FAIL mid_reset got pend=%0d en=%b addr=%h data=%h hold=%b done=%b err=%b st=%0d required 0 0 0 0 1 0 0 %0d",
               exp_q.size(), bif.boot_wr_en, bif.boot_wr_addr, bif.boot_wr_data, bif.core_hold, bif.boot_done,
               bif.boot_err, dbg_state, S_SYNC);
    end
    @(negedge clk);
    reset = 1'b1;
    repeat (4) @(negedge clk);
    a = $urandom;
    rand_payload(2);
    model_frame(a, -1);
    send_frame(a, payload_xor(), -1, -1);
    repeat (4) @(negedge clk);
    checks++;
    if ({exp_q.size() == 0, bif.boot_done, bif.boot_err, bif.core_hold} !== 4'b1100) begin
      errors++;
      $display("FAIL post_reset_frame got pend=%0d done=%b err=%b hold=%b required 0 1 0 0",
               exp_q.size(), bif.boot_done, bif.boot_err, bif.core_hold);
    end
  endtask

  task automatic test_random_frames();
    logic [31:0] a;
    logic [7:0] chk;
    logic corrupt;
    for (int k = 0; k < 3; k++) begin
      do_reset();
      a = $urandom;
      rand_payload($urandom_range(1, 5));
      corrupt = 1'($urandom_range(0, 1));
      chk = payload_xor() ^ (corrupt ? 8'($urandom_range(1, 255)) : 8'h00);
      model_frame(a, -1);
      send_frame(a, chk, -1, -1);
      repeat (4) @(negedge clk);
      checks++;
      if ({exp_q.size() == 0, bif.boot_done, bif.boot_err, bif.core_hold} !== {1'b1, !corrupt, corrupt, corrupt}) begin
        errors++;
        $display("FAIL random_%0d got pend=%0d done=%b err=%b hold=%b required 0 %b %b %b",
                 k, exp_q.size(), bif.boot_done, bif.boot_err, bif.core_hold, !corrupt, corrupt, corrupt);
      end
    end
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_bad_checksum();
    test_noise_glitch();
    test_framing_error();
    test_edge_lengths();
    test_reset_mid_data();
    test_random_frames();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/boot_loader.md
Name: boot_loader

Overview:
- UART-fed boot loader. It drives the SoC boot write port (boot_wr_en / boot_wr_addr / boot_wr_data) from a framed serial image.
- Holds the core in reset until an image has been written and its checksum verified.
- Sits at SoC top level, between the board UART pin and the slave memory boot port.

Parameters:
- CLKS_PER_BIT, 434, clk cycles per UART bit (50 MHz / 115200); legal range 16..65535.
- SYNC_BYTE, 8'hA5, frame start marker.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-low reset
- uart_rx  input  1  serial input, idle high, 8N1, LSB first; asynchronous to clk
- boot_wr_en  output  1  one-cycle byte write strobe
- boot_wr_addr  output  32  byte address for the current write
- boot_wr_data  output  8  byte data for the current write
- core_hold  output  1  1 = keep core in reset; OR'd into the core reset by the top level
- boot_done  output  1  image loaded and checksum verified (sticky)
- boot_err  output  1  checksum or framing error on the last frame (sticky until next SYNC_BYTE)

Behaviour:
- Reset values: boot_wr_en=0, boot_wr_addr=0, boot_wr_data=0, core_hold=1, boot_done=0, boot_err=0. The FSM goes to SYNC.
- RX front end:
  - uart_rx passes through a 2-flop synchronizer.
  - A start bit is a high-to-low transition seen while idle.
  - Start is re-checked at CLKS_PER_BIT/2 and rejected as a glitch if high.
  - Data bits are sampled every CLKS_PER_BIT after that, LSB first, then the stop bit.
  - Output is a one-cycle rx_valid with rx_byte, plus rx_ferr when the stop bit is 0.
- Frame format, bytes in order:
  - SYNC_BYTE
  - ADDR[7:0], ADDR[15:8], ADDR[23:16], ADDR[31:24]
  - LEN[7:0] .. LEN[31:24]
  - LEN payload bytes
  - CHK, which is the XOR of all payload bytes
- FSM states and transitions:
  - SYNC: discard bytes until rx_byte==SYNC_BYTE, then clear boot_err and go to ADDR.
  - ADDR: shift in 4 bytes, then go to LEN.
  - LEN: shift in 4 bytes. If LEN==0 go to CHK, else go to DATA.
  - DATA: on each rx_valid, drive boot_wr_en=1 for exactly one cycle, with boot_wr_addr=ADDR+idx and boot_wr_data=rx_byte.
    - Write latency is 1 cycle after rx_valid.
    - Update the running XOR and increment idx (32-bit).
    - After byte LEN-1, go to CHK.
  - CHK: on rx_valid, if rx_byte equals the running XOR go to DONE, else set boot_err=1 and go to SYNC.
  - DONE: boot_done=1 and core_hold=0, both registered (1 cycle after the CHK byte). All further RX is ignored until reset.
- Address arithmetic is modulo 2^32. ADDR+idx wraps silently from 32'hFFFFFFFF to 0.
- Framing error (rx_ferr) in any state except SYNC and DONE: set boot_err=1, drop the byte, go to SYNC.
  - Writes already issued are not rolled back.
  - core_hold stays 1.
- rx_ferr in SYNC is ignored.
- boot_wr_en is never asserted outside DATA. boot_wr_addr/data hold their last value when boot_wr_en=0.
- Reset mid-frame: all state is cleared immediately (async), and the next frame must start with SYNC_BYTE.
- Since rx_valid is one cycle wide and bytes arrive at most once per 10·CLKS_PER_BIT, no buffering is required.

Decomposition:
- Shared package boot_pkg holds:
  - the boot_state_e enum (SYNC, ADDR, LEN, DATA, CHK, DONE)
  - the SYNC_BYTE default
  - the frame field byte counts (ADDR_BYTES=4, LEN_BYTES=4)
- Sub-module boot_uart_rx:
  - synchronizer, baud counter and bit FSM (IDLE, START, BITS, STOP)
  - outputs rx_valid, rx_byte, rx_ferr
- Top boot_loader holds the frame FSM, the XOR accumulator and the address/index counters.

Test Plan:
- Good frame: A5, 00 01 00 00 (ADDR=0x100), 03 00 00 00, payload 11 22 33, checksum 00 -> three writes: 0x100=0x11, 0x101=0x22, 0x102=0x33, each a one-cycle boot_wr_en; then boot_done=1, core_hold=0, boot_err=0.
- Bad checksum: same frame with checksum 0x55 -> the 3 writes occur, then boot_err=1, core_hold=1, FSM in SYNC. A following correct frame clears boot_err and ends with boot_done=1.
- Noise and glitch: bytes 00 FF 3C before A5, plus a uart_rx low pulse of CLKS_PER_BIT/4 while idle -> no writes and no byte decoded from the glitch; the subsequent valid frame loads normally.
- Framing error: stop bit forced 0 on the second payload byte -> one write only, boot_err=1, return to SYNC, core_hold=1.
- Edge lengths and wrap: LEN=0 with checksum 00 -> no writes, boot_done=1. ADDR=0xFFFFFFFF with LEN=2 -> writes to 0xFFFFFFFF then 0x00000000.
- Reset mid-DATA (reset low for 2 cycles after the 1st payload byte) -> all outputs return to reset values; after reset release, a fresh frame completes correctly.
